// File: rtl/fir_interp2_seq.sv
// 2x interpolating FIR: one 16x16 MAC per clock, two polyphase outputs per input.
// Phase 0 uses the even taps of the 19-tap low-pass, phase 1 the odd taps.
module fir_interp2_seq #(
    parameter int DW  = 16,
    parameter int AW  = 36,
    parameter int OSH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [2:0] {IDLE, MAC0, OUT0, MAC1, OUT1} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   h_q [10];
    logic [DW-1:0]   h_d [10];
    logic [AW-1:0]   acc_q, acc_d;
    logic [3:0]      k_q, k_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    logic [4:0]      cidx;
    logic [DW-1:0]   coef;
    logic [DW-1:0]   tap;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   sum;
    logic [DW-1:0]   sat;

    always_comb begin
        unique case (cidx)
            5'd0, 5'd18: coef = 16'd26;
            5'd1, 5'd17: coef = 16'd270;
            5'd2, 5'd16: coef = 16'd963;
            5'd3, 5'd15: coef = 16'd2424;
            5'd4, 5'd14: coef = 16'd4869;
            5'd5, 5'd13: coef = 16'd8259;
            5'd6, 5'd12: coef = 16'd12194;
            5'd7, 5'd11: coef = 16'd15948;
            5'd8, 5'd10: coef = 16'd18666;
            5'd9:        coef = 16'd19660;
            default:     coef = 16'd0;
        endcase
    end

    assign cidx = {k_q, (state_q == MAC1)};
    assign tap  = (k_q <= 4'd9) ? h_q[k_q] : '0;
    assign prod = coef * tap;
    assign sum  = acc_q + {{(AW-2*DW){1'b0}}, prod};
    // Anything above the 16-bit output slice means the result clips.
    assign sat  = (|sum[AW-1:OSH+DW]) ? '1 : sum[OSH+DW-1:OSH];

    assign in_ready  = reset && (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    for (int i = 9; i > 0; i--) h_d[i] = h_q[i-1];
                    h_d[0]  = in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC0;
                end
            end
            MAC0, MAC1: begin
                acc_d = sum;
                k_d   = k_q + 4'd1;
                if ((state_q == MAC0 && k_q == 4'd9) ||
                    (state_q == MAC1 && k_q == 4'd8)) begin
                    out_data_d  = sat;
                    out_valid_d = 1'b1;
                    state_d     = (state_q == MAC0) ? OUT0 : OUT1;
                end
            end
            OUT0, OUT1: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    k_d         = '0;
                    state_d     = (state_q == OUT0) ? MAC1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < 10; i++) h_q[i] <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_interp2_seq.sv
// Bench for fir_interp2_seq: reference model feeds a scoreboard on every
// accepted input, and directed steps cover timing, backpressure and reset.
module tb_fir_interp2_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int unsigned cm [19] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948,
                             18666, 19660, 18666, 15948, 12194, 8259, 4869,
                             2424, 963, 270, 26};
    int imp_tab [20] = '{25, 269, 962, 2423, 4868, 8258, 12193, 15947, 18665,
                         19659, 18665, 15947, 12193, 8258, 4868, 2423, 962,
                         269, 25, 0};

    logic [15:0] hm [10];
    int sbq [$];
    int seen [$];
    int acc_cyc [$];
    int vcyc [$];

    fir_interp2_seq dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int ph);
        longint s = 0;
        for (int k = 0; k < 10; k++)
            if (2*k + ph < 19) s += longint'(cm[2*k+ph]) * hm[k];
        s = s >>> 16;
        return (s > 65535) ? 65535 : int'(s);
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
            for (int i = 0; i < 10; i++) hm[i] = '0;
        end else begin
            if (in_valid && in_ready) begin
                for (int i = 9; i > 0; i--) hm[i] = hm[i-1];
                hm[0] = in_data;
                sbq.push_back(model(0));
                sbq.push_back(model(1));
                acc_cyc.push_back(cyc + 1);
            end
            if (out_valid) vcyc.push_back(cyc);
            if (out_valid && out_ready) begin
                chk("sb_empty_at_output", sbq.size() == 0, 0);
                if (sbq.size() != 0) chk("out_data", out_data, sbq.pop_front());
                seen.push_back(out_data);
            end
        end
    end

    task automatic send(input logic [15:0] d);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        chk("send_accept_timeout", !in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", n >= 400, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("wait_valid_timeout", out_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d0;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // Impulse response
        seen.delete();
        send(16'hFFFF);
        repeat (10) send(16'h0000);
        drain();
        chk("imp_count", seen.size(), 22);
        for (int i = 0; i < 20; i++)
            if (i < seen.size()) chk($sformatf("imp_%0d", i), seen[i], imp_tab[i]);

        // DC level
        seen.delete();
        repeat (12) send(16'd1000);
        drain();
        for (int i = 18; i < 24; i++)
            if (i < seen.size()) chk($sformatf("dc_%0d", i), seen[i], 1120);

        // Saturation
        seen.delete();
        repeat (10) send(16'hFFFF);
        drain();
        chk("sat_p0", seen.size() >= 20 ? seen[18] : -1, 65535);
        chk("sat_p1", seen.size() >= 20 ? seen[19] : -1, 65535);

        // Backpressure in OUT0
        out_ready = 1'b0;
        send(16'd1234);
        wait_valid();
        d0 = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 2);
            in_data  = 16'd777;
            @(negedge clk);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_data_hold", out_data, d0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_mac1_started", out_valid, 0);
        chk("bp_mac1_in_ready", in_ready, 0);
        drain();

        // Reset while MAC1 is in progress
        send(16'hFFFF);
        wait_valid();
        repeat (4) @(posedge clk);
        #1; reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready_rel", in_ready, 1);
        seen.delete();
        send(16'hFFFF);
        drain();
        chk("post_rst_p0", seen.size() > 0 ? seen[0] : -1, 25);
        chk("post_rst_p1", seen.size() > 1 ? seen[1] : -1, 269);

        // Continuous traffic timing
        acc_cyc.delete();
        vcyc.delete();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'd500;
        n = 0;
        while (acc_cyc.size() < 3 && n < 200) begin @(negedge clk); n++; end
        chk("timing_accept_timeout", acc_cyc.size(), 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        if (acc_cyc.size() == 3) begin
            chk("acc_gap_0", acc_cyc[1] - acc_cyc[0], 22);
            chk("acc_gap_1", acc_cyc[2] - acc_cyc[1], 22);
        end
        chk("valid_cycles", vcyc.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < vcyc.size() && i/2 < acc_cyc.size())
                chk($sformatf("valid_at_%0d", i), vcyc[i],
                    acc_cyc[i/2] + ((i % 2) ? 20 : 10));

        chk("sb_leftover", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_interp2_seq.md
Name: fir_interp2_seq

Overview:
- Sequential 2x interpolating FIR. It is the upsampling counterpart of the 19-tap low-pass decimating path, using the same 19-tap symmetric coefficient set split into two polyphase branches.
- Accepts 16-bit unsigned samples on a valid/ready input. Emits two output samples per input on a valid/ready output: phase 0, then phase 1.
- A single time-shared 16x16 multiplier-accumulator computes one product per clock. It sits between a low-rate sample source and the full-rate processing chain.

Parameters:
- DW, 16, input/output sample width (fixed at 16 for this revision).
- AW, 36, accumulator width.
- OSH, 16, output slice LSB: out = acc[OSH+15:OSH], with saturation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (reset==0 resets on the next rising clk edge).
- in_data  in  16  input sample, unsigned.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample (high only in IDLE and reset deasserted).
- out_data  out  16  interpolated sample, unsigned, registered.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Coefficients (constant ROM): c[0..18] = 26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660, 18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26.
  - Phase 0 uses c[2k], k=0..9 (10 taps, sum 73436).
  - Phase 1 uses c[2k+1], k=0..8 (9 taps, sum 73462).
- History: 10-entry register line h[0..9]; h[0] is the newest sample.
  - On an input handshake (in_valid & in_ready at an edge): h[k] <= h[k-1] for k=1..9, and h[0] <= in_data.
- State machine: IDLE -> MAC0 -> OUT0 -> MAC1 -> OUT1 -> IDLE.
  - IDLE: in_ready=1, out_valid=0. A handshake loads the history, clears acc, sets tap index k=0, and goes to MAC0.
  - MAC0: each edge does acc += c[2k]*h[k], k++. On the edge with k=9, out_data <= sat16((acc + product) >> 16), out_valid <= 1, state goes to OUT0.
  - OUT0: hold out_data and out_valid. When out_valid & out_ready at an edge: out_valid <= 0, acc <= 0, k <= 0, state goes to MAC1.
  - MAC1: same as MAC0 with c[2k+1], k=0..8. The final edge is k=8, then state goes to OUT1.
  - OUT1: hold until the output handshake, then go to IDLE.
- Arithmetic:
  - Unsigned 16x16 -> 32-bit products, 36-bit accumulate; overflow cannot occur (max < 2^33).
  - sat16: if the result exceeds 65535, output 65535.
  - Truncation, no rounding.
- Latency and throughput:
  - Accept at edge E0 -> phase-0 out_valid visible after E10.
  - With out_ready=1: phase-0 handshake at E11, phase-1 valid after E20, handshake at E21, in_ready high after E21.
  - Next accept no earlier than E22, giving 22 cycles per input at full rate.
- Backpressure:
  - out_valid stays high and out_data stays stable until the handshake.
  - in_ready is 0 in every state except IDLE.
  - in_valid while in_ready=0 is ignored; the source must hold its data.
- Reset (reset==0 at an edge, from any state including mid-MAC or mid-OUT):
  - state=IDLE, h[0..9]=0, acc=0, k=0, out_data=0, out_valid=0.
  - An in-flight computation is discarded and no partial output is ever emitted.
  - in_ready=0 while reset is low, and 1 on the first cycle after release.
- Startup: the history is zero-initialised, so the first 9 input samples produce the defined transient. There is no priming phase and no suppressed outputs.
- out_valid never rises in IDLE, MAC0 or MAC1.

Test Plan:
- Impulse (reset, in=65535, then zeros, out_ready=1): outputs are 25, 269 | 962, 2423 | 4868, 8258 | 12193, 15947 | 18665, 19659 | 18665, 15947 | ... | 25, 0, i.e. c[j]-1 for each j, then 0.
- DC in=1000 for 12 samples: from the 10th input onward, every output is 1120 (both phases).
- Saturation, DC in=65535: steady-state phase-0 and phase-1 outputs both equal 65535 (unsaturated values would be 73434 and 73460).
- Backpressure: hold out_ready=0 for 5 cycles in OUT0 -> out_data and out_valid unchanged, in_ready=0, and an in_valid pulse is not accepted; releasing out_ready gives a handshake on the next edge, then MAC1 starts.
- Timing, in_valid=1 and out_ready=1 continuous: accepts at edges 0, 22, 44; out_valid is high only during the cycles after edges 10 and 20 (and 32, 42, ...).
- Reset mid-MAC1 (reset low 1 cycle) -> out_valid=0 and out_data=0 next cycle, in_ready=1 after release, and a following 65535 impulse first yields 25 (history cleared).
